tc_sram_arbiter: RTL and testbench

Round-robin arbiter that shares one port of a `tc_sram` macro among `NumReq` requesters.
- Upstream: one req/gnt request channel per requester.
- Downstream: one SRAM port with fixed read latency `Latency`.
- Tracks in-flight reads so each read response returns only to its issuer.
- Sits between compute-side requesters, e.g. tensor-core operand fetchers and result writers, and a single SRAM port.

---
 rtl/tc_sram_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_tc_sram_arbiter.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tc_sram_arbiter.sv
// ---------------------------------------------------------------------------
// tc_sram_arbiter
//
// Round-robin arbiter sharing one tc_sram port among NumReq requesters.
// Grants are combinational from req_i and the rotating priority pointer. The
// winner's request drives the SRAM port in the same cycle. A Latency-deep
// {valid, idx} tracker routes each read response back to its issuer.
//
// Optional feature macro: TC_SRAM_ARB_PRIO0_EN
//   defined   : requester 0 wins whenever it requests and leaves the pointer
//               untouched; requesters 1..NumReq-1 rotate among themselves.
//   undefined : pure round-robin over all requesters.
//
// Ports
//   clk_i         clock
//   rst_ni        synchronous active-low reset
//   req_i         per-requester request
//   we_i          per-requester write enable
//   addr_i        per-requester word address
//   wdata_i       per-requester write data
//   be_i          per-requester byte enables
//   gnt_o         grant, one-hot or zero (combinational)
//   rvalid_o      read response valid, one-hot or zero
//   rdata_o       shared read data (pass-through of sram_rdata_i)
//   sram_*_o      request to the SRAM port, all zero when idle
//   sram_rdata_i  SRAM read data
// ---------------------------------------------------------------------------
module tc_sram_arbiter #(
  parameter int unsigned NumReq    = 4,
  parameter int unsigned NumWords  = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned ByteWidth = 8,
  parameter int unsigned Latency   = 1,
  localparam int unsigned AddrWidth = (NumWords > 32'd1) ? $clog2(NumWords) : 32'd1,
  localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 32'd1) / ByteWidth,
  localparam int unsigned IdxWidth  = (NumReq > 32'd1) ? $clog2(NumReq) : 32'd1
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NumReq-1:0]                   req_i,
  input  logic [NumReq-1:0]                   we_i,
  input  logic [NumReq-1:0][AddrWidth-1:0]    addr_i,
  input  logic [NumReq-1:0][DataWidth-1:0]    wdata_i,
  input  logic [NumReq-1:0][BeWidth-1:0]      be_i,
  output logic [NumReq-1:0]                   gnt_o,
  output logic [NumReq-1:0]                   rvalid_o,
  output logic [DataWidth-1:0]                rdata_o,
  output logic                                sram_req_o,
  output logic                                sram_we_o,
  output logic [AddrWidth-1:0]                sram_addr_o,
  output logic [DataWidth-1:0]                sram_wdata_o,
  output logic [BeWidth-1:0]                  sram_be_o,
  input  logic [DataWidth-1:0]                sram_rdata_i
);

  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumReq - 32'd1);

  logic [IdxWidth-1:0] ptr_r;
  logic [IdxWidth-1:0] ptr_nxt_s;
  logic [IdxWidth-1:0] win_idx_s;
  logic                win_found_s;
  logic                ptr_upd_s;
  logic                rd_accept_s;
  logic [NumReq-1:0]   gnt_s;

  // Winner selection: first requester found searching cyclically from ptr_r.
  always_comb begin
    int unsigned         cand;
    logic [IdxWidth-1:0] cand_idx;
    cand        = 32'd0;
    cand_idx    = '0;
    win_found_s = 1'b0;
    win_idx_s   = '0;
    ptr_upd_s   = 1'b1;
    for (int unsigned k = 0; k < NumReq; k++) begin
      cand     = (32'(ptr_r) + k) % NumReq;
      cand_idx = cand[IdxWidth-1:0];
`ifdef TC_SRAM_ARB_PRIO0_EN
      // Requester 0 is handled separately below, so the rotation skips it.
      if (!win_found_s && req_i[cand_idx] && (cand_idx != '0)) begin
`else
      if (!win_found_s && req_i[cand_idx]) begin
`endif
        win_found_s = 1'b1;
        win_idx_s   = cand_idx;
      end else begin
      end
    end
`ifdef TC_SRAM_ARB_PRIO0_EN
    // Absolute priority for requester 0; the rotation state is left alone.
    if (req_i[0]) begin
      win_found_s = 1'b1;
      win_idx_s   = '0;
      ptr_upd_s   = 1'b0;
    end else begin
      ptr_upd_s   = 1'b1;
    end
`endif
    // No grant may be issued while reset is held.
    if (!rst_ni) begin
      win_found_s = 1'b0;
    end else begin
    end
  end

  // Grant vector, SRAM request mux and next pointer value.
  always_comb begin
    gnt_s        = '0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_be_o    = '0;
    ptr_nxt_s    = ptr_r;
    if (win_found_s) begin
      gnt_s[win_idx_s] = 1'b1;
      sram_we_o        = we_i[win_idx_s];
      sram_addr_o      = addr_i[win_idx_s];
      sram_wdata_o     = wdata_i[win_idx_s];
      sram_be_o        = be_i[win_idx_s];
    end else begin
    end
    if (win_found_s && ptr_upd_s) begin
      ptr_nxt_s = (win_idx_s == LastIdx) ? '0 : (win_idx_s + IdxWidth'(1));
    end else begin
    end
  end

  assign gnt_o       = gnt_s;
  assign sram_req_o  = win_found_s;
  assign rd_accept_s = win_found_s & ~we_i[win_idx_s];
  assign rdata_o     = sram_rdata_i;

  // Priority pointer register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_r <= '0;
    end else begin
      ptr_r <= ptr_nxt_s;
    end
  end

  if (Latency == 0) begin : g_lat0
    // Zero-latency SRAM: the response is valid in the accepting cycle.
    always_comb begin
      rvalid_o = '0;
      if (rd_accept_s) begin
        rvalid_o[win_idx_s] = 1'b1;
      end else begin
      end
    end
  end else begin : g_track
    logic [Latency-1:0]                vld_r;
    logic [Latency-1:0][IdxWidth-1:0]  idx_r;

    // Read tracker shift register; writes and idle cycles enter as invalid.
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        vld_r <= '0;
        idx_r <= '0;
      end else begin
        vld_r[0] <= rd_accept_s;
        idx_r[0] <= win_idx_s;
        for (int s = 1; s < int'(Latency); s++) begin
          vld_r[s] <= vld_r[s-1];
          idx_r[s] <= idx_r[s-1];
        end
      end
    end

    // Response routing from the oldest tracker entry.
    always_comb begin
      rvalid_o = '0;
      if (vld_r[Latency-1]) begin
        rvalid_o[idx_r[Latency-1]] = 1'b1;
      end else begin
      end
    end
  end

endmodule

// File: tb/tb_tc_sram_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for tc_sram_arbiter. Three instances with Latency 0, 1 and 3 share
// the same requester stimulus; each has its own behavioural SRAM. A reference
// model (rotating priority integer, word array, response queues) predicts
// grants, SRAM port values and read responses.
// ---------------------------------------------------------------------------
module tb_tc_sram_arbiter;

  typedef struct {
    int          due;
    int          idx;
    logic [31:0] data;
  } resp_t;

  logic                  clk = 1'b0;
  logic                  rst_ni;
  logic                  load;
  logic [3:0]            req;
  logic [3:0]            we;
  logic [3:0][4:0]       addr;
  logic [3:0][31:0]      wdata;
  logic [3:0][3:0]       be;
  logic [31:0]           init_mem [32];

  // reference model state
  logic [31:0] ref_mem [32];
  int          ref_ptr;
  int          cyc;
  resp_t       q1[$];
  resp_t       q3[$];

  // observed / expected per cycle (index 0: L0, 1: L1, 2: L3)
  logic [3:0]  o_gnt [3];
  logic [3:0]  o_rv  [3];
  logic [31:0] o_rd  [3];
  logic        o_sreq, o_swe;
  logic [4:0]  o_saddr;
  logic [31:0] o_swdata;
  logic [3:0]  o_sbe;
  logic [3:0]  e_gnt;
  logic [3:0]  e_rv  [3];
  logic [31:0] e_rd  [3];
  logic        e_sreq, e_swe;
  logic [4:0]  e_saddr;
  logic [31:0] e_swdata;
  logic [3:0]  e_sbe;

  int n_chk;
  int n_fail;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 2) ? 3 : g;
    logic [3:0]  gnt, rv, sbe;
    logic [31:0] rd, swdata, srd;
    logic        sreq, swe;
    logic [4:0]  saddr;
    logic [31:0] mem  [32];
    logic [31:0] pipe [4];

    tc_sram_arbiter #(
      .NumReq(4), .NumWords(32), .DataWidth(32), .ByteWidth(8), .Latency(LAT)
    ) u_dut (
      .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .we_i(we), .addr_i(addr),
      .wdata_i(wdata), .be_i(be), .gnt_o(gnt), .rvalid_o(rv), .rdata_o(rd),
      .sram_req_o(sreq), .sram_we_o(swe), .sram_addr_o(saddr),
      .sram_wdata_o(swdata), .sram_be_o(sbe), .sram_rdata_i(srd)
    );

    if (LAT == 0) begin : g_l0
      assign srd = mem[saddr];
    end else begin : g_lp
      assign srd = pipe[LAT-1];
    end

    // Behavioural SRAM with a fixed read latency.
    always @(posedge clk) begin
      if (load) begin
        mem <= init_mem;
      end else if (sreq && swe) begin
        for (int b = 0; b < 4; b++)
          if (sbe[b]) mem[saddr][8*b +: 8] <= swdata[8*b +: 8];
      end
      pipe[0] <= (sreq && !swe) ? mem[saddr] : 32'hxxxxxxxx;
      for (int s = 1; s < 4; s++) pipe[s] <= pipe[s-1];
    end
  end

  function automatic int ref_winner(input logic [3:0] r, input int p);
    int c;
`ifdef TC_SRAM_ARB_PRIO0_EN
    if (r[0]) return 0;
    for (int k = 0; k < 4; k++) begin
      c = (p + k) % 4;
      if (c != 0 && r[c]) return c;
    end
`else
    for (int k = 0; k < 4; k++) begin
      c = (p + k) % 4;
      if (r[c]) return c;
    end
`endif
    return -1;
  endfunction

  // One clock cycle: predict, sample the DUTs mid-cycle, then advance the model.
  task automatic tick();
    int w;
    @(negedge clk); #1;
    w = rst_ni ? ref_winner(req, ref_ptr) : -1;
    e_gnt = (w >= 0) ? 4'(1 << w) : 4'b0000;
    if (w >= 0) begin
      e_sreq = 1'b1; e_swe = we[w]; e_saddr = addr[w]; e_swdata = wdata[w]; e_sbe = be[w];
      e_rv[0] = we[w] ? 4'b0000 : e_gnt;
      e_rd[0] = ref_mem[addr[w]];
    end else begin
      e_sreq = 1'b0; e_swe = 1'b0; e_saddr = 5'd0; e_swdata = 32'd0; e_sbe = 4'd0;
      e_rv[0] = 4'b0000;
      e_rd[0] = 32'd0;
    end
    e_rv[1] = (q1.size() > 0 && q1[0].due == cyc) ? 4'(1 << q1[0].idx) : 4'b0000;
    e_rd[1] = (q1.size() > 0) ? q1[0].data : 32'd0;
    e_rv[2] = (q3.size() > 0 && q3[0].due == cyc) ? 4'(1 << q3[0].idx) : 4'b0000;
    e_rd[2] = (q3.size() > 0) ? q3[0].data : 32'd0;
    o_gnt[0] = g_dut[0].gnt; o_rv[0] = g_dut[0].rv; o_rd[0] = g_dut[0].rd;
    o_gnt[1] = g_dut[1].gnt; o_rv[1] = g_dut[1].rv; o_rd[1] = g_dut[1].rd;
    o_gnt[2] = g_dut[2].gnt; o_rv[2] = g_dut[2].rv; o_rd[2] = g_dut[2].rd;
    o_sreq = g_dut[1].sreq; o_swe = g_dut[1].swe; o_saddr = g_dut[1].saddr;
    o_swdata = g_dut[1].swdata; o_sbe = g_dut[1].sbe;
    @(posedge clk); #1;
    if (q1.size() > 0 && q1[0].due == cyc) void'(q1.pop_front());
    if (q3.size() > 0 && q3[0].due == cyc) void'(q3.pop_front());
    if (!rst_ni) begin
      q1.delete(); q3.delete(); ref_ptr = 0;
    end else if (w >= 0) begin
      if (we[w]) begin
        for (int b = 0; b < 4; b++)
          if (be[w][b]) ref_mem[addr[w]][8*b +: 8] = wdata[w][8*b +: 8];
      end else begin
        q1.push_back('{cyc + 1, w, ref_mem[addr[w]]});
        q3.push_back('{cyc + 3, w, ref_mem[addr[w]]});
      end
`ifdef TC_SRAM_ARB_PRIO0_EN
      if (w != 0) ref_ptr = (w + 1) % 4;
`else
      ref_ptr = (w + 1) % 4;
`endif
    end
    cyc++;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; load = 1'b1; req = 4'b1111; we = 4'b0000;
    tick(); tick();
    n_chk++;
    if (o_gnt[1] !== 4'b0000 || o_sreq !== 1'b0) begin
      n_fail++; $display("FAIL reset_gnt: gnt=%b req=%b, need 0000/0", o_gnt[1], o_sreq);
    end
    n_chk++;
    if ({o_swe, o_saddr, o_swdata, o_sbe} !== 42'd0) begin
      n_fail++; $display("FAIL reset_sram: we=%b addr=%h wdata=%h be=%b, need all zero",
                         o_swe, o_saddr, o_swdata, o_sbe);
    end
    for (int g = 0; g < 3; g++) begin
      n_chk++;
      if (o_rv[g] !== 4'b0000) begin
        n_fail++; $display("FAIL reset_rvalid[%0d]: got %b need 0000", g, o_rv[g]);
      end
    end
    load = 1'b0; rst_ni = 1'b1; req = 4'b0000;
  endtask

  task automatic test_single_read();
    req = 4'b0100; we = 4'b0000; addr[2] = 5'd5;
    tick();
    n_chk++;
    if (o_gnt[1] !== 4'b0100 || o_sreq !== 1'b1 || o_saddr !== 5'd5 || o_swe !== 1'b0) begin
      n_fail++; $display("FAIL single_gnt: gnt=%b sreq=%b addr=%0d we=%b need 0100/1/5/0",
                         o_gnt[1], o_sreq, o_saddr, o_swe);
    end
    n_chk++;
    if (o_rv[0] !== 4'b0100 || o_rd[0] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL single_l0: rv=%b rd=%h need 0100/deadbeef", o_rv[0], o_rd[0]);
    end
    req = 4'b0000;
    tick();
    n_chk++;
    if (o_rv[1] !== 4'b0100 || o_rd[1] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL single_l1: rv=%b rd=%h need 0100/deadbeef", o_rv[1], o_rd[1]);
    end
    tick(); tick();
    n_chk++;
    if (o_rv[2] !== 4'b0100 || o_rd[2] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL single_l3: rv=%b rd=%h need 0100/deadbeef", o_rv[2], o_rd[2]);
    end
    tick();
  endtask

  task automatic test_contention();
    int ei;
    int pi;
    rst_ni = 1'b0; tick(); rst_ni = 1'b1;
    req = 4'b1111; we = 4'b0000;
    for (int i = 0; i < 4; i++) addr[i] = 5'(8 + i);
    pi = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
`ifdef TC_SRAM_ARB_PRIO0_EN
      ei = 0;
`else
      ei = k % 4;
`endif
      n_chk++;
      if (o_gnt[1] !== 4'(1 << ei)) begin
        n_fail++; $display("FAIL contention_gnt k=%0d: got %b need %b", k, o_gnt[1], 4'(1 << ei));
      end
      if (k > 0) begin
        n_chk++;
        if (o_rv[1] !== 4'(1 << pi) || o_rd[1] !== ref_mem[8 + pi]) begin
          n_fail++; $display("FAIL contention_rv k=%0d: rv=%b rd=%h need %b/%h",
                             k, o_rv[1], o_rd[1], 4'(1 << pi), ref_mem[8 + pi]);
        end
      end
      pi = ei;
    end
    req = 4'b0000;
    tick();
    n_chk++;
    if (o_rv[1] !== 4'(1 << pi) || o_rd[1] !== ref_mem[8 + pi]) begin
      n_fail++; $display("FAIL contention_last: rv=%b need %b", o_rv[1], 4'(1 << pi));
    end
    tick(); tick(); tick();
  endtask

  task automatic test_write_read();
    req = 4'b0010; we = 4'b0010; addr[1] = 5'd3; wdata[1] = 32'h12345678; be[1] = 4'b0011;
    tick();
    n_chk++;
    if (o_gnt[1] !== 4'b0010 || o_swe !== 1'b1 || o_sbe !== 4'b0011 || o_swdata !== 32'h12345678) begin
      n_fail++; $display("FAIL wr_port: gnt=%b we=%b be=%b wdata=%h need 0010/1/0011/12345678",
                         o_gnt[1], o_swe, o_sbe, o_swdata);
    end
    req = 4'b0001; we = 4'b0000; addr[0] = 5'd3;
    tick();
    n_chk++;
    if (o_gnt[1] !== 4'b0001 || o_rv[0] !== 4'b0001 || o_rd[0] !== 32'hFFFF5678) begin
      n_fail++; $display("FAIL rd_after_wr_l0: gnt=%b rv=%b rd=%h need 0001/0001/ffff5678",
                         o_gnt[1], o_rv[0], o_rd[0]);
    end
    req = 4'b0000;
    tick();
    n_chk++;
    if (o_rv[1] !== 4'b0001 || o_rd[1] !== 32'hFFFF5678) begin
      n_fail++; $display("FAIL rd_after_wr_l1: rv=%b rd=%h need 0001/ffff5678", o_rv[1], o_rd[1]);
    end
    tick(); tick();
    n_chk++;
    if (o_rv[2] !== 4'b0001 || o_rd[2] !== 32'hFFFF5678) begin
      n_fail++; $display("FAIL rd_after_wr_l3: rv=%b rd=%h need 0001/ffff5678", o_rv[2], o_rd[2]);
    end
    tick();
  endtask

  task automatic test_pipeline();
    logic [3:0] pats [6];
    pats = '{4'b1000, 4'b0010, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
    we = 4'b0000; addr[3] = 5'd10; addr[1] = 5'd11; addr[2] = 5'd12;
    for (int j = 0; j < 6; j++) begin
      req = pats[j];
      tick();
      if (j < 3) begin
        n_chk++;
        if (o_gnt[1] !== pats[j]) begin
          n_fail++; $display("FAIL pipe_gnt j=%0d: got %b need %b", j, o_gnt[1], pats[j]);
        end
      end else begin
        n_chk++;
        if (o_rv[2] !== pats[j-3] || o_rd[2] !== ref_mem[10 + j - 3]) begin
          n_fail++; $display("FAIL pipe_rv j=%0d: rv=%b rd=%h need %b/%h",
                             j, o_rv[2], o_rd[2], pats[j-3], ref_mem[10 + j - 3]);
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    req = 4'b0010; we = 4'b0000; addr[1] = 5'd13;
    tick();
    n_chk++;
    if (o_gnt[1] !== 4'b0010) begin
      n_fail++; $display("FAIL mid_gnt: got %b need 0010", o_gnt[1]);
    end
    rst_ni = 1'b0; req = 4'b1111;
    tick();
    n_chk++;
    if (o_gnt[0] !== 4'b0000 || o_gnt[1] !== 4'b0000 || o_gnt[2] !== 4'b0000) begin
      n_fail++; $display("FAIL mid_gnt_in_reset: got %b %b %b need 0000", o_gnt[0], o_gnt[1], o_gnt[2]);
    end
    rst_ni = 1'b1; req = 4'b0000;
    for (int j = 0; j < 2; j++) begin
      tick();
      n_chk++;
      if (o_rv[2] !== 4'b0000) begin
        n_fail++; $display("FAIL mid_drop j=%0d: rv=%b need 0000", j, o_rv[2]);
      end
    end
    req = 4'b1110;
    tick();
    n_chk++;
    if (o_gnt[1] !== 4'b0010) begin
      n_fail++; $display("FAIL ptr_after_reset: gnt=%b need 0010", o_gnt[1]);
    end
    req = 4'b0000;
    tick(); tick(); tick();
  endtask

`ifdef TC_SRAM_ARB_PRIO0_EN
  task automatic test_prio0();
    req = 4'b0101; we = 4'b0000; addr[0] = 5'd1; addr[2] = 5'd2;
    for (int j = 0; j < 3; j++) begin
      tick();
      n_chk++;
      if (o_gnt[1] !== 4'b0001) begin
        n_fail++; $display("FAIL prio0_hold j=%0d: got %b need 0001", j, o_gnt[1]);
      end
    end
    req = 4'b0100;
    tick();
    n_chk++;
    if (o_gnt[1] !== 4'b0100) begin
      n_fail++; $display("FAIL prio0_release: got %b need 0100", o_gnt[1]);
    end
    req = 4'b0000;
    tick(); tick(); tick();
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst_ni = ($urandom_range(0, 39) != 0);
      for (int i = 0; i < 4; i++) begin
        if (!req[i] && $urandom_range(0, 1) == 1) begin
          req[i]   = 1'b1;
          we[i]    = ($urandom_range(0, 2) == 0);
          addr[i]  = 5'($urandom_range(0, 7));
          wdata[i] = $urandom;
          be[i]    = 4'($urandom_range(0, 15));
        end
      end
      tick();
      for (int g = 0; g < 3; g++) begin
        n_chk++;
        if (o_gnt[g] !== e_gnt) begin
          n_fail++; $display("FAIL rnd_gnt[%0d] cyc=%0d: got %b need %b", g, cyc, o_gnt[g], e_gnt);
        end
        n_chk++;
        if (o_rv[g] !== e_rv[g] || (e_rv[g] != 4'b0000 && o_rd[g] !== e_rd[g])) begin
          n_fail++; $display("FAIL rnd_resp[%0d] cyc=%0d: rv=%b rd=%h need %b/%h",
                             g, cyc, o_rv[g], o_rd[g], e_rv[g], e_rd[g]);
        end
      end
      n_chk++;
      if ({o_sreq, o_swe, o_saddr, o_swdata, o_sbe} !== {e_sreq, e_swe, e_saddr, e_swdata, e_sbe}) begin
        n_fail++; $display("FAIL rnd_sram cyc=%0d: req=%b we=%b addr=%h wd=%h be=%b need %b/%b/%h/%h/%b",
                           cyc, o_sreq, o_swe, o_saddr, o_swdata, o_sbe,
                           e_sreq, e_swe, e_saddr, e_swdata, e_sbe);
      end
      for (int i = 0; i < 4; i++)
        if (e_gnt[i]) req[i] = 1'b0;
    end
    rst_ni = 1'b1; req = 4'b0000;
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0; ref_ptr = 0;
    rst_ni = 1'b0; load = 1'b1; req = 4'b0000; we = 4'b0000;
    addr = '0; wdata = '0; be = '0;
    for (int i = 0; i < 32; i++) init_mem[i] = $urandom;
    init_mem[5] = 32'hDEADBEEF;
    init_mem[3] = 32'hFFFFFFFF;
    ref_mem = init_mem;
    test_reset();
    test_single_read();
    test_contention();
    test_write_read();
    test_pipeline();
    test_reset_midflight();
`ifdef TC_SRAM_ARB_PRIO0_EN
    test_prio0();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
